mas_prog_loader: RTL and testbench

- Parametrised program-load and instruction-fetch unit for the MAS16 CPU family; successor to the fixed 16-bit, pg-gated instruction load path.
- Adds configurable word width and depth, a valid/ready load handshake, end-of-program detection, program-length reporting, overflow/abort error flags, and a registered fetch port that returns a NOP word beyond the loaded program.
- Sits between the external programming interface (pg, pg_instr) and the core's fetch stage.

---
 rtl/mas_prog_loader_if.sv | 29 ++
 rtl/mas_prog_loader.sv | 126 ++++++++++++
 tb/tb_mas_prog_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mas_prog_loader_if.sv
// Program-load and fetch bus between the programming/fetch side and the loader.
interface mas_prog_loader_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
);
  logic              pg;
  logic              pg_valid;
  logic [DATA_W-1:0] pg_instr;
  logic              pg_ready;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_valid;
  logic [ADDR_W:0]   prog_len;
  logic              prog_done;
  logic              prog_err;

  // Programming interface and fetch stage side.
  modport master (
    output pg, pg_valid, pg_instr, fetch_en, fetch_addr,
    input  pg_ready, fetch_instr, fetch_valid, prog_len, prog_done, prog_err
  );

  // Loader side.
  modport slave (
    input  pg, pg_valid, pg_instr, fetch_en, fetch_addr,
    output pg_ready, fetch_instr, fetch_valid, prog_len, prog_done, prog_err
  );
endinterface

// File: rtl/mas_prog_loader.sv
// MAS16 program loader: valid/ready word load into a local program memory with
// end-marker detection, overflow/abort flags and a 1-cycle registered fetch port.
module mas_prog_loader #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [3:0]        END_OP   = 4'hF,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input logic              clk,
  input logic              rstz,
  mas_prog_loader_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   prog_len_q;
  logic              done_q;
  logic              err_q;
  logic              pg_q;
  logic [DATA_W-1:0] fetch_instr_q;
  logic              fetch_valid_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic pg_ready;
  logic accept;
  logic is_end;
  logic last_slot;
  logic fetch_hit;
  logic in_prog;

  assign pg_ready  = (state_q == StLoad) && bus.pg;
  assign accept    = pg_ready && bus.pg_valid;
  assign is_end    = (bus.pg_instr[DATA_W-1 -: 4] == END_OP);
  assign last_slot = (wr_ptr_q == ADDR_W'(DEPTH - 1));
  assign fetch_hit = (state_q == StDone) && !bus.pg && bus.fetch_en;
  // Zero-extend so an address compares correctly against a full-depth length.
  assign in_prog   = ({1'b0, bus.fetch_addr} < prog_len_q);

  assign bus.pg_ready    = pg_ready;
  assign bus.fetch_instr = fetch_instr_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.prog_len    = prog_len_q;
  assign bus.prog_done   = done_q;
  assign bus.prog_err    = err_q;

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= bus.pg_instr;
    end
  end

  // Load controller FSM with registered status outputs.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pg_q       <= 1'b0;
    end else begin
      pg_q <= bus.pg;
      case (state_q)
        StIdle: begin
          if (bus.pg) begin
            state_q  <= StLoad;
            wr_ptr_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        StLoad: begin
          if (!bus.pg) begin
            // Abort: programming mode left before an end marker arrived.
            state_q    <= StErr;
            prog_len_q <= {1'b0, wr_ptr_q};
            err_q      <= 1'b1;
          end else if (bus.pg_valid) begin
            if (is_end) begin
              // End marker takes priority even in the last slot.
              state_q    <= StDone;
              prog_len_q <= {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);
              done_q     <= 1'b1;
            end else if (last_slot) begin
              state_q    <= StErr;
              prog_len_q <= (ADDR_W + 1)'(DEPTH);
              err_q      <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
          end
        end
        StDone, StErr: begin
          // Only a fresh rising edge of pg restarts; a held pg does not.
          if (bus.pg && !pg_q) begin
            state_q  <= StLoad;
            wr_ptr_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Registered fetch port; out-of-program addresses return the NOP word.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      fetch_instr_q <= NOP_WORD;
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_hit;
      if (fetch_hit) begin
        fetch_instr_q <= in_prog ? mem[bus.fetch_addr] : NOP_WORD;
      end
    end
  end

endmodule

// File: tb/tb_mas_prog_loader.sv
// Directed bench for mas_prog_loader: a full-size instance and a 4-deep instance.
module tb_mas_prog_loader;

  logic clk  = 1'b0;
  logic rstz = 1'b0;
  always #5 clk = ~clk;

  mas_prog_loader_if #(.DATA_W(16), .ADDR_W(8)) ifa ();
  mas_prog_loader_if #(.DATA_W(16), .ADDR_W(2)) ifb ();

  mas_prog_loader #(.DATA_W(16), .ADDR_W(8), .END_OP(4'hF), .NOP_WORD(16'h0000)) dut_a (
    .clk (clk),
    .rstz(rstz),
    .bus (ifa.slave)
  );

  mas_prog_loader #(.DATA_W(16), .ADDR_W(2), .END_OP(4'hF), .NOP_WORD(16'h0000)) dut_b (
    .clk (clk),
    .rstz(rstz),
    .bus (ifb.slave)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_a [256];
  int          len_a    = 0;
  bit          served_a = 1'b0;
  logic [15:0] last_a   = 16'h0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lw_a(input logic [15:0] w, input int idx);
    ifa.pg_valid = 1'b1;
    ifa.pg_instr = w;
    model_a[idx] = w;
    step();
  endtask

  // Stall cycle carrying an end-marker pattern that must not be taken.
  task automatic stall_a();
    ifa.pg_valid = 1'b0;
    ifa.pg_instr = 16'hFFFF;
    step();
  endtask

  task automatic fetch_a(input logic [7:0] a);
    exp_t e;
    exp_t p;
    ifa.fetch_en   = 1'b1;
    ifa.fetch_addr = a;
    if (served_a) begin
      e.v    = 1'b1;
      e.d    = (int'(a) < len_a) ? model_a[a] : 16'h0000;
      last_a = e.d;
    end else begin
      e.v = 1'b0;
      e.d = last_a;
    end
    sb.push_back(e);
    step();
    p = sb.pop_front();
    chk($sformatf("a_fetch_valid@%0d", a), 32'(ifa.fetch_valid), 32'(p.v));
    chk($sformatf("a_fetch_instr@%0d", a), 32'(ifa.fetch_instr), 32'(p.d));
  endtask

  task automatic status_a(input string tag, input bit done, input bit err, input int len);
    chk({tag, "_done"}, 32'(ifa.prog_done), 32'(done));
    chk({tag, "_err"}, 32'(ifa.prog_err), 32'(err));
    chk({tag, "_len"}, 32'(ifa.prog_len), 32'(len));
  endtask

  initial begin
    exp_t eb;
    exp_t pb;
    ifa.pg = 0; ifa.pg_valid = 0; ifa.pg_instr = '0; ifa.fetch_en = 0; ifa.fetch_addr = '0;
    ifb.pg = 0; ifb.pg_valid = 0; ifb.pg_instr = '0; ifb.fetch_en = 0; ifb.fetch_addr = '0;

    // Reset values
    #2;
    status_a("rst", 1'b0, 1'b0, 0);
    chk("rst_pg_ready", 32'(ifa.pg_ready), 32'd0);
    chk("rst_fetch_valid", 32'(ifa.fetch_valid), 32'd0);
    chk("rst_fetch_instr", 32'(ifa.fetch_instr), 32'h0000);
    chk("rst_b_len", 32'(ifb.prog_len), 32'd0);
    #1 rstz = 1'b1;

    // Back-to-back load, held pg, then fetch 0..4
    ifa.pg = 1'b1;
    step();
    chk("load_pg_ready", 32'(ifa.pg_ready), 32'd1);
    lw_a(16'h0001, 0); lw_a(16'h0502, 1); lw_a(16'h0A03, 2); lw_a(16'hF000, 3);
    ifa.pg_valid = 1'b0;
    status_a("p1", 1'b1, 1'b0, 4);
    chk("p1_ready_done", 32'(ifa.pg_ready), 32'd0);
    step(); step();
    chk("p1_held_done", 32'(ifa.prog_done), 32'd1);
    chk("p1_held_ready", 32'(ifa.pg_ready), 32'd0);
    ifa.pg = 1'b0;
    step();
    len_a = 4; served_a = 1'b1;
    for (int a = 0; a < 5; a++) fetch_a(8'(a));
    ifa.fetch_en = 1'b0;

    // Fetch with pg=1 is refused; rising pg restarts a stalled load
    ifa.pg = 1'b1; served_a = 1'b0;
    fetch_a(8'd0);
    ifa.fetch_en = 1'b0;
    chk("p2_flags_cleared", 32'(ifa.prog_done), 32'd0);
    chk("p2_pg_ready", 32'(ifa.pg_ready), 32'd1);
    stall_a(); lw_a(16'h0001, 0);
    stall_a(); lw_a(16'h0502, 1);
    stall_a(); lw_a(16'h0A03, 2);
    stall_a(); lw_a(16'hF000, 3);
    ifa.pg_valid = 1'b0;
    status_a("p2", 1'b1, 1'b0, 4);
    ifa.pg = 1'b0;
    step();
    served_a = 1'b1;
    for (int a = 0; a < 5; a++) fetch_a(8'(a));
    ifa.fetch_en = 1'b0;

    // Abort after two words
    ifa.pg = 1'b1; served_a = 1'b0;
    step();
    lw_a(16'h0001, 0); lw_a(16'h0002, 1);
    ifa.pg_valid = 1'b0;
    ifa.pg = 1'b0;
    step();
    status_a("abort", 1'b0, 1'b1, 2);
    fetch_a(8'd0);
    ifa.fetch_en = 1'b0;

    // Reload to DONE, then pulse pg and load a short program
    ifa.pg = 1'b1;
    step();
    lw_a(16'h0001, 0); lw_a(16'h0502, 1); lw_a(16'h0A03, 2); lw_a(16'hF000, 3);
    ifa.pg_valid = 1'b0;
    ifa.pg = 1'b0;
    step();
    chk("p4a_done", 32'(ifa.prog_done), 32'd1);
    ifa.pg = 1'b1;
    step();
    lw_a(16'h1234, 0); lw_a(16'hF000, 1);
    ifa.pg_valid = 1'b0;
    ifa.pg = 1'b0;
    step();
    status_a("p4", 1'b1, 1'b0, 2);
    len_a = 2; served_a = 1'b1;
    fetch_a(8'd0); fetch_a(8'd2); fetch_a(8'd1);
    ifa.fetch_en = 1'b0;

    // 4-deep instance: overflow, then end marker in the last slot
    ifb.pg = 1'b1;
    step();
    chk("b_pg_ready", 32'(ifb.pg_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      ifb.pg_valid = 1'b1;
      ifb.pg_instr = 16'(i + 1);
      step();
    end
    ifb.pg_valid = 1'b0;
    chk("b_ovf_err", 32'(ifb.prog_err), 32'd1);
    chk("b_ovf_done", 32'(ifb.prog_done), 32'd0);
    chk("b_ovf_len", 32'(ifb.prog_len), 32'd4);
    chk("b_ovf_ready", 32'(ifb.pg_ready), 32'd0);
    ifb.pg = 1'b0;
    step();
    ifb.pg = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      ifb.pg_valid = 1'b1;
      ifb.pg_instr = (i == 3) ? 16'hF000 : 16'(i + 1);
      step();
    end
    ifb.pg_valid = 1'b0;
    chk("b_end_done", 32'(ifb.prog_done), 32'd1);
    chk("b_end_err", 32'(ifb.prog_err), 32'd0);
    chk("b_end_len", 32'(ifb.prog_len), 32'd4);
    ifb.pg = 1'b0;
    step();
    ifb.fetch_en   = 1'b1;
    ifb.fetch_addr = 2'd3;
    eb.v = 1'b1; eb.d = 16'hF000;
    sb.push_back(eb);
    step();
    pb = sb.pop_front();
    chk("b_fetch_valid", 32'(ifb.fetch_valid), 32'(pb.v));
    chk("b_fetch_instr", 32'(ifb.fetch_instr), 32'(pb.d));
    ifb.fetch_en = 1'b0;

    // Asynchronous reset in the middle of a load
    ifa.pg = 1'b1; served_a = 1'b0;
    step();
    lw_a(16'h0011, 0); lw_a(16'h0022, 1);
    ifa.pg_valid = 1'b0;
    #2 rstz = 1'b0;
    #1;
    status_a("mrst", 1'b0, 1'b0, 0);
    chk("mrst_pg_ready", 32'(ifa.pg_ready), 32'd0);
    chk("mrst_fetch_valid", 32'(ifa.fetch_valid), 32'd0);
    chk("mrst_fetch_instr", 32'(ifa.fetch_instr), 32'h0000);
    last_a = 16'h0000;
    ifa.pg = 1'b0;
    #1 rstz = 1'b1;
    step();
    ifa.pg = 1'b1;
    step();
    chk("mrst_reload_ready", 32'(ifa.pg_ready), 32'd1);
    lw_a(16'h0777, 0); lw_a(16'hF001, 1);
    ifa.pg_valid = 1'b0;
    ifa.pg = 1'b0;
    step();
    status_a("mrst_reload", 1'b1, 1'b0, 2);
    len_a = 2; served_a = 1'b1;
    fetch_a(8'd0); fetch_a(8'd1); fetch_a(8'd2);
    ifa.fetch_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
